cond_writeback: RTL and testbench
=================================

COND_WRITEBACK -- requirements
Module: cond_writeback

Interface
REQ-001 clk  in  1  single clock, all state rising-edge.
REQ-002 reset  in  1  synchronous, active-high.
REQ-003 valid_in  in  1  ALU result/flags valid this cycle.
REQ-004 ready_out  out  1  block accepts; transfer = valid_in & ready_out.
REQ-005 Cond  in  4  ARM condition field of the op.
REQ-006 FlagW  in  2  [1] update N,Z; [0] update C,V.
REQ-007 ALUFlags  in  5  {Q,N,Z,C,V} from ALU.
REQ-008 Result, Result2  in  32 each  low/high result words.
REQ-009 RegW, LongW  in  1 each  write Rd; write RdHi:RdLo pair.
REQ-010 RdLo, RdHi  in  4 each  destination register indices.
REQ-011 q_clr  in  1  clear sticky Q.
REQ-012 rf_we  out  1; rf_wa  out  4; rf_wd  out  32  single register-file write port, registered.
REQ-013 Flags  out  5  registered {Q,N,Z,C,V}.
REQ-014 CondEx  out  1  registered pass/fail of last accepted op.

Function
REQ-015 Condition SHALL be evaluated on the transfer cycle against current Flags (pre-update): 0000 EQ Z, 0001 NE !Z, 0010 CS C, 0011 CC !C, 0100 MI N, 0101 PL !N, 0110 VS V, 0111 VC !V, 1000 HI C&!Z, 1001 LS !C|Z, 1010 GE N==V, 1011 LT N!=V, 1100 GT !Z&(N==V), 1101 LE Z|(N!=V), 1110 AL 1, 1111 never 0.
REQ-016 On transfer with pass, Flags SHALL update at next edge: N,Z if FlagW[1]; C,V if FlagW[0]; Q set if ALUFlags[4].
REQ-017 Failed condition SHALL leave Flags, rf_we unchanged (rf_we=0).
REQ-018 Q SHALL be sticky; q_clr clears at next edge; same-cycle Q set and q_clr: set wins.
REQ-019 FSM states IDLE, HI_PEND; ready_out = (state==IDLE).
REQ-020 IDLE, transfer, pass, RegW: next cycle rf_we=1, rf_wa=RdLo, rf_wd=Result; latency 1.
REQ-021 Same with LongW=1: next cycle Lo write, state HI_PEND; following cycle rf_we=1, rf_wa=RdHi, rf_wd=Result2 (latched), return IDLE.
REQ-022 LongW with fail SHALL stay IDLE, no writes.
REQ-023 Single-word ops SHALL sustain one transfer per cycle; long ops one per two cycles.
REQ-024 RdHi==RdLo: both writes issued, Hi value final.
REQ-025 valid_in while ready_out=0 SHALL be ignored (not consumed).
REQ-026 CondEx SHALL reflect pass of most recent transfer, held otherwise.

Reset
REQ-027 reset SHALL force state IDLE, rf_we=0, rf_wa=0, rf_wd=0, Flags=0, CondEx=0; reset during HI_PEND aborts the Hi write.

Configuration
REQ-028 COND_WB_Q_EN defined: sticky Q per REQ-016/018; undefined: Flags[4] constant 0, ALUFlags[4] and q_clr ignored.

Structure
REQ-029 Package cond_wb_pkg SHALL hold condition-code constants, flag bit indices (Q=4..V=0), FSM state enum.
REQ-030 Combinational evaluator SHALL be sub-module cond_check (Cond, Flags[3:0] -> pass).

Verification
REQ-031 Flags=0, Cond=1110, RegW, RdLo=3, Result=0x12345678, FlagW=11, ALUFlags=0b01000 -> next cycle write R3=0x12345678, Flags=0b01000.
REQ-032 Flags Z=1, Cond=0001 (NE), RegW -> rf_we stays 0, CondEx=0, Flags unchanged.
REQ-033 LongW, RdLo=4, RdHi=5, Result=0xFFFFFFFE, Result2=0x00000001, AL -> R4 at T+1, R5 at T+2, ready_out=0 at T+1.
REQ-034 ALUFlags[4]=1 pass -> Q=1; later op with Q=0 keeps Q=1; q_clr -> Q=0; q_clr with Q set same cycle -> Q=1 (with COND_WB_Q_EN); macro off -> Q always 0.
REQ-035 reset asserted in HI_PEND -> no R5 write, state IDLE, all outputs 0 next cycle.
REQ-036 Back-to-back 4 AL single ops -> 4 consecutive write cycles, ready_out constant 1.

Source files
------------

// File: rtl/cond_wb_pkg.sv
// Shared definitions for the conditional writeback block: ARM condition
// codes, bit positions inside the {Q,N,Z,C,V} flag word and FSM states.
package cond_wb_pkg;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    // Flag word is {Q,N,Z,C,V}; the low four bits double as the NZCV nibble.
    localparam int FLAG_Q = 4;
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic {
        IDLE    = 1'b0,
        HI_PEND = 1'b1
    } wb_state_e;

endpackage

// File: rtl/cond_check.sv
// Combinational ARM condition-code evaluator: Cond against NZCV -> pass.
module cond_check
    import cond_wb_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] nzcv,
    output logic       pass
);

    logic n, z, c, v;
    assign n = nzcv[FLAG_N];
    assign z = nzcv[FLAG_Z];
    assign c = nzcv[FLAG_C];
    assign v = nzcv[FLAG_V];

    // Decode the condition field into a single pass/fail bit.
    always_comb begin
        pass = 1'b0;
        case (cond)
            COND_EQ: pass = z;
            COND_NE: pass = !z;
            COND_CS: pass = c;
            COND_CC: pass = !c;
            COND_MI: pass = n;
            COND_PL: pass = !n;
            COND_VS: pass = v;
            COND_VC: pass = !v;
            COND_HI: pass = c & !z;
            COND_LS: pass = !c | z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = !z & (n == v);
            COND_LE: pass = z | (n != v);
            COND_AL: pass = 1'b1;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_writeback.sv
// Conditional writeback stage: evaluates the op's condition against the
// current flags, updates flags and drives a single registered register-file
// write port. Long (64-bit) results take two write cycles, Lo then Hi.
// Optional feature: define COND_WB_Q_EN for the sticky Q (saturation) flag;
// without it Flags[4] is tied to 0 and ALUFlags[4] / q_clr are ignored.
module cond_writeback
    import cond_wb_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_in,
    output logic        ready_out,
    input  logic [3:0]  Cond,
    input  logic [1:0]  FlagW,
    input  logic [4:0]  ALUFlags,
    input  logic [31:0] Result,
    input  logic [31:0] Result2,
    input  logic        RegW,
    input  logic        LongW,
    input  logic [3:0]  RdLo,
    input  logic [3:0]  RdHi,
    input  logic        q_clr,
    output logic        rf_we,
    output logic [3:0]  rf_wa,
    output logic [31:0] rf_wd,
    output logic [4:0]  Flags,
    output logic        CondEx
);

    wb_state_e   state_q;
    logic        rf_we_q;
    logic [3:0]  rf_wa_q;
    logic [31:0] rf_wd_q;
    logic [3:0]  nzcv_q;
    logic        q_q;
    logic        condex_q;
    logic [3:0]  hi_wa_q;
    logic [31:0] hi_wd_q;

    logic cond_pass;
    logic xfer;

    // Condition is judged against the flags as they stand before this op.
    cond_check u_cond_check (
        .cond (Cond),
        .nzcv (nzcv_q),
        .pass (cond_pass)
    );

    assign ready_out = (state_q == IDLE);
    assign xfer      = valid_in & ready_out;

    assign rf_we  = rf_we_q;
    assign rf_wa  = rf_wa_q;
    assign rf_wd  = rf_wd_q;
    assign Flags  = {q_q, nzcv_q};
    assign CondEx = condex_q;

    // Writeback FSM: accepts ops in IDLE, issues the deferred Hi word in HI_PEND.
    // rf_wa/rf_wd hold their last value while rf_we is low.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            rf_we_q  <= 1'b0;
            rf_wa_q  <= 4'd0;
            rf_wd_q  <= 32'd0;
            nzcv_q   <= 4'd0;
            condex_q <= 1'b0;
            hi_wa_q  <= 4'd0;
            hi_wd_q  <= 32'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    rf_we_q <= 1'b0;
                    if (xfer) begin
                        condex_q <= cond_pass;
                        if (cond_pass) begin
                            if (FlagW[1]) begin
                                nzcv_q[FLAG_N] <= ALUFlags[FLAG_N];
                                nzcv_q[FLAG_Z] <= ALUFlags[FLAG_Z];
                            end
                            if (FlagW[0]) begin
                                nzcv_q[FLAG_C] <= ALUFlags[FLAG_C];
                                nzcv_q[FLAG_V] <= ALUFlags[FLAG_V];
                            end
                            // A long op always writes its Lo word first.
                            if (RegW || LongW) begin
                                rf_we_q <= 1'b1;
                                rf_wa_q <= RdLo;
                                rf_wd_q <= Result;
                            end
                            if (LongW) begin
                                hi_wa_q <= RdHi;
                                hi_wd_q <= Result2;
                                state_q <= HI_PEND;
                            end
                        end
                    end
                end
                HI_PEND: begin
                    rf_we_q <= 1'b1;
                    rf_wa_q <= hi_wa_q;
                    rf_wd_q <= hi_wd_q;
                    state_q <= IDLE;
                end
                default: begin
                    rf_we_q <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef COND_WB_Q_EN
    // Sticky Q: set by a passing op with ALU Q, cleared by q_clr; set wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            q_q <= 1'b0;
        end else if (xfer && cond_pass && ALUFlags[FLAG_Q]) begin
            q_q <= 1'b1;
        end else if (q_clr) begin
            q_q <= 1'b0;
        end
    end
`else
    assign q_q = 1'b0;
    wire unused_q_inputs = ALUFlags[FLAG_Q] ^ q_clr;
`endif

endmodule

// File: tb/tb_cond_writeback.sv
// Self-checking bench for cond_writeback: a directed vector table with
// hand-written expectations, then a random phase checked by a scoreboard.
module tb_cond_writeback;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        valid_in = 1'b0;
    logic        ready_out;
    logic [3:0]  Cond = 4'd0;
    logic [1:0]  FlagW = 2'd0;
    logic [4:0]  ALUFlags = 5'd0;
    logic [31:0] Result = 32'd0;
    logic [31:0] Result2 = 32'd0;
    logic        RegW = 1'b0;
    logic        LongW = 1'b0;
    logic [3:0]  RdLo = 4'd0;
    logic [3:0]  RdHi = 4'd0;
    logic        q_clr = 1'b0;
    logic        rf_we;
    logic [3:0]  rf_wa;
    logic [31:0] rf_wd;
    logic [4:0]  Flags;
    logic        CondEx;

    cond_writeback dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .ready_out(ready_out),
        .Cond(Cond), .FlagW(FlagW), .ALUFlags(ALUFlags), .Result(Result),
        .Result2(Result2), .RegW(RegW), .LongW(LongW), .RdLo(RdLo), .RdHi(RdHi),
        .q_clr(q_clr), .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
        .Flags(Flags), .CondEx(CondEx)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        valid;
        logic [3:0]  cond;
        logic [1:0]  flagw;
        logic [4:0]  aluf;
        logic        regw;
        logic        longw;
        logic [3:0]  rdlo;
        logic [3:0]  rdhi;
        logic [31:0] res;
        logic [31:0] res2;
        logic        qclr;
        logic        chk;       // table expectations valid
        logic        exp_we;
        logic [3:0]  exp_nzcv;
    } vec_t;

    typedef struct {
        logic        we;
        logic [3:0]  wa;
        logic [31:0] wd;
        logic [4:0]  flags;
        logic        condex;
        logic        ready;
        logic        addr_chk;
    } exp_t;

    int n_checks = 0;
    int n_fail   = 0;
    exp_t sb[$];

    // reference model state
    logic        m_pend;
    logic        m_we;
    logic [3:0]  m_wa;
    logic [31:0] m_wd;
    logic [4:0]  m_flags;
    logic        m_condex;
    logic [3:0]  m_hwa;
    logic [31:0] m_hwd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cc, v;
        n = f[3]; z = f[2]; cc = f[1]; v = f[0];
        case (c)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return cc;
            4'h3: return !cc;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return cc && !z;
            4'h9: return !cc || z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return z || (n != v);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic vec_t mk(input logic rst, input logic valid, input logic [3:0] cond,
                                input logic [1:0] flagw, input logic [4:0] aluf,
                                input logic regw, input logic longw,
                                input logic [3:0] rdlo, input logic [3:0] rdhi,
                                input logic [31:0] res, input logic [31:0] res2,
                                input logic qclr, input logic exp_we, input logic [3:0] exp_nzcv);
        vec_t v;
        v.rst = rst; v.valid = valid; v.cond = cond; v.flagw = flagw; v.aluf = aluf;
        v.regw = regw; v.longw = longw; v.rdlo = rdlo; v.rdhi = rdhi;
        v.res = res; v.res2 = res2; v.qclr = qclr;
        v.chk = 1'b1; v.exp_we = exp_we; v.exp_nzcv = exp_nzcv;
        return v;
    endfunction

    task automatic model_step(input vec_t v, output exp_t e);
        logic rdy, x, p;
        rdy = !m_pend;
        x   = v.valid && rdy;
        p   = cond_ok(v.cond, m_flags[3:0]);
        e.addr_chk = 1'b0;
        if (v.rst) begin
            m_pend = 0; m_we = 0; m_wa = 0; m_wd = 0; m_flags = 0; m_condex = 0;
            m_hwa = 0; m_hwd = 0;
            e.addr_chk = 1'b1;
        end else begin
            m_we = 0;
            if (m_pend) begin
                m_we = 1; m_wa = m_hwa; m_wd = m_hwd; m_pend = 0;
            end else if (x) begin
                m_condex = p;
                if (p) begin
                    if (v.flagw[1]) m_flags[3:2] = v.aluf[3:2];
                    if (v.flagw[0]) m_flags[1:0] = v.aluf[1:0];
                    if (v.regw || v.longw) begin
                        m_we = 1; m_wa = v.rdlo; m_wd = v.res;
                    end
                    if (v.longw) begin
                        m_hwa = v.rdhi; m_hwd = v.res2; m_pend = 1;
                    end
                end
            end
`ifdef COND_WB_Q_EN
            if (x && p && v.aluf[4]) m_flags[4] = 1'b1;
            else if (v.qclr)         m_flags[4] = 1'b0;
`else
            m_flags[4] = 1'b0;
`endif
        end
        e.we = m_we; e.wa = m_wa; e.wd = m_wd; e.flags = m_flags;
        e.condex = m_condex; e.ready = !m_pend;
        if (m_we) e.addr_chk = 1'b1;
    endtask

    // Drive one cycle at negedge, predict, then compare after the next edge.
    task automatic apply(input vec_t v, input int idx);
        exp_t e, got;
        string tag;
        reset = v.rst; valid_in = v.valid; Cond = v.cond; FlagW = v.flagw;
        ALUFlags = v.aluf; RegW = v.regw; LongW = v.longw; RdLo = v.rdlo;
        RdHi = v.rdhi; Result = v.res; Result2 = v.res2; q_clr = v.qclr;
        model_step(v, e);
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        tag = $sformatf("[%0d]", idx);
        if (sb.size() == 0) begin
            chk({"scoreboard_empty", tag}, 1, 0);
        end else begin
            got = sb.pop_front();
            chk({"rf_we", tag}, rf_we, got.we);
            if (got.addr_chk) begin
                chk({"rf_wa", tag}, rf_wa, got.wa);
                chk({"rf_wd", tag}, rf_wd, got.wd);
            end
            chk({"Flags", tag}, Flags, got.flags);
            chk({"CondEx", tag}, CondEx, got.condex);
            chk({"ready_out", tag}, ready_out, got.ready);
        end
        if (v.chk) begin
            chk({"tbl_rf_we", tag}, rf_we, v.exp_we);
            chk({"tbl_nzcv", tag}, Flags[3:0], v.exp_nzcv);
        end
    endtask

    vec_t tbl[$];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        m_pend = 0; m_we = 0; m_wa = 0; m_wd = 0; m_flags = 0; m_condex = 0;
        m_hwa = 0; m_hwd = 0;

        //          rst v  cond   fw     aluf      rw lw lo    hi    res           res2          qc we nzcv
        tbl.push_back(mk(1, 0, 4'hE, 2'b00, 5'b00000, 0, 0, 4'd0, 4'd0, 32'h0,        32'h0,        0, 0, 4'b0000));
        tbl.push_back(mk(0, 1, 4'hE, 2'b11, 5'b01000, 1, 0, 4'd3, 4'd0, 32'h12345678, 32'h0,        0, 1, 4'b1000));
        tbl.push_back(mk(0, 1, 4'h0, 2'b11, 5'b00100, 1, 0, 4'd1, 4'd0, 32'h11111111, 32'h0,        0, 0, 4'b1000));
        tbl.push_back(mk(0, 1, 4'hE, 2'b10, 5'b00100, 0, 0, 4'd0, 4'd0, 32'h0,        32'h0,        0, 0, 4'b0100));
        tbl.push_back(mk(0, 1, 4'h1, 2'b11, 5'b01111, 1, 0, 4'd2, 4'd0, 32'h22222222, 32'h0,        0, 0, 4'b0100));
        tbl.push_back(mk(0, 1, 4'hE, 2'b00, 5'b00000, 0, 1, 4'd4, 4'd5, 32'hFFFFFFFE, 32'h00000001, 0, 1, 4'b0100));
        tbl.push_back(mk(0, 1, 4'hE, 2'b11, 5'b11111, 1, 0, 4'd7, 4'd0, 32'h77777777, 32'h0,        0, 1, 4'b0100));
        tbl.push_back(mk(0, 1, 4'hE, 2'b01, 5'b00011, 1, 0, 4'd8, 4'd0, 32'h88888888, 32'h0,        0, 1, 4'b0111));
        tbl.push_back(mk(0, 1, 4'hE, 2'b00, 5'b00000, 1, 0, 4'd9, 4'd0, 32'h99999999, 32'h0,        0, 1, 4'b0111));
        tbl.push_back(mk(0, 1, 4'hE, 2'b00, 5'b00000, 1, 0, 4'd10,4'd0, 32'hAAAAAAAA, 32'h0,        0, 1, 4'b0111));
        tbl.push_back(mk(0, 1, 4'hE, 2'b00, 5'b00000, 1, 0, 4'd11,4'd0, 32'hBBBBBBBB, 32'h0,        0, 1, 4'b0111));
        tbl.push_back(mk(0, 1, 4'h9, 2'b11, 5'b00000, 1, 0, 4'd12,4'd0, 32'hC0C0C0C0, 32'h0,        0, 1, 4'b0000));
        tbl.push_back(mk(0, 1, 4'hA, 2'b11, 5'b01001, 1, 0, 4'd13,4'd0, 32'hD0D0D0D0, 32'h0,        0, 1, 4'b1001));
        tbl.push_back(mk(0, 1, 4'hB, 2'b11, 5'b00000, 1, 0, 4'd14,4'd0, 32'hE0E0E0E0, 32'h0,        0, 0, 4'b1001));
        tbl.push_back(mk(0, 1, 4'hC, 2'b11, 5'b00010, 1, 0, 4'd14,4'd0, 32'hE1E1E1E1, 32'h0,        0, 1, 4'b0010));
        tbl.push_back(mk(0, 1, 4'hF, 2'b11, 5'b01111, 1, 0, 4'd15,4'd0, 32'hF0F0F0F0, 32'h0,        0, 0, 4'b0010));
        tbl.push_back(mk(0, 1, 4'h2, 2'b00, 5'b00000, 0, 1, 4'd6, 4'd6, 32'h0000000A, 32'h0000000B, 0, 1, 4'b0010));
        tbl.push_back(mk(0, 0, 4'hE, 2'b00, 5'b00000, 0, 0, 4'd0, 4'd0, 32'h0,        32'h0,        0, 1, 4'b0010));
        tbl.push_back(mk(0, 1, 4'h3, 2'b11, 5'b01111, 0, 1, 4'd1, 4'd2, 32'h1,        32'h2,        0, 0, 4'b0010));
        tbl.push_back(mk(0, 0, 4'hE, 2'b00, 5'b00000, 0, 0, 4'd0, 4'd0, 32'h0,        32'h0,        0, 0, 4'b0010));
        tbl.push_back(mk(0, 1, 4'hE, 2'b00, 5'b10000, 0, 0, 4'd0, 4'd0, 32'h0,        32'h0,        0, 0, 4'b0010));
        tbl.push_back(mk(0, 1, 4'hE, 2'b00, 5'b00000, 0, 0, 4'd0, 4'd0, 32'h0,        32'h0,        0, 0, 4'b0010));
        tbl.push_back(mk(0, 0, 4'hE, 2'b00, 5'b00000, 0, 0, 4'd0, 4'd0, 32'h0,        32'h0,        1, 0, 4'b0010));
        tbl.push_back(mk(0, 1, 4'hE, 2'b00, 5'b10000, 0, 0, 4'd0, 4'd0, 32'h0,        32'h0,        1, 0, 4'b0010));
        tbl.push_back(mk(0, 1, 4'hE, 2'b00, 5'b00000, 0, 1, 4'd4, 4'd5, 32'hFFFFFFFE, 32'h00000001, 0, 1, 4'b0010));
        tbl.push_back(mk(1, 0, 4'hE, 2'b00, 5'b00000, 0, 0, 4'd0, 4'd0, 32'h0,        32'h0,        0, 0, 4'b0000));
        tbl.push_back(mk(0, 1, 4'h0, 2'b11, 5'b01111, 1, 0, 4'd9, 4'd0, 32'h5,        32'h0,        0, 0, 4'b0000));

        @(negedge clk);
        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

        // Q flag bit directly: pinned to 0 without the feature
`ifndef COND_WB_Q_EN
        chk("q_disabled", Flags[4], 1'b0);
`endif

        // random traffic checked only by the scoreboard model
        for (int i = 0; i < 400; i++) begin
            v.rst   = ($urandom_range(0, 39) == 0);
            v.valid = ($urandom_range(0, 3) != 0);
            v.cond  = 4'($urandom_range(0, 15));
            v.flagw = 2'($urandom_range(0, 3));
            v.aluf  = 5'($urandom_range(0, 31));
            v.regw  = $urandom_range(0, 1);
            v.longw = ($urandom_range(0, 3) == 0);
            v.rdlo  = 4'($urandom_range(0, 15));
            v.rdhi  = 4'($urandom_range(0, 15));
            v.res   = $urandom;
            v.res2  = $urandom;
            v.qclr  = ($urandom_range(0, 7) == 0);
            v.chk   = 1'b0; v.exp_we = 1'b0; v.exp_nzcv = 4'd0;
            apply(v, 100 + i);
        end

        chk("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
